serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//   Bit-serial adder front-end that drives the team's FA_using_HA full-adder
//   cell one bit per clock. It accepts two WIDTH-bit operands plus carry-in
//   over a valid/ready handshake and presents them LSB-first to the cell,
//   registering the carry between cycles. It assembles the sum serially and
//   returns it with carry-out over a second valid/ready handshake. It trades
//   latency for area in the adder datapath.
// PARAMETERS
//   WIDTH    4   operand/sum width in bits; legal range 2..32
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      reset, asynchronous assert, active-low
//   in_valid   in   1      operand set a/b/cin valid
//   in_ready   out  1      block can accept operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in for bit 0
//   out_valid  out  1      sum/cout valid, held until taken
//   out_ready  in   1      consumer takes the result this cycle
//   sum        out  WIDTH  a+b+cin modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      high in RUN state
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; out_valid=0, sum=0, cout=0, busy=0.
//     Internal shift registers, carry flop and bit counter are cleared.
//     Reset mid-RUN or in DONE discards the operation; no result is produced.
//   FSM states: IDLE, RUN, DONE.
//     IDLE: in_ready=1. If in_valid, capture a->a_sh, b->b_sh, cin->carry,
//       cnt=0, sum_sh=0, then go to RUN.
//     RUN: in_ready=0, busy=1. Each cycle:
//       fa = FA(a_sh[0], b_sh[0], carry)
//       sum_sh <= {fa.sum, sum_sh[WIDTH-1:1]}
//       carry <= fa.cout; a_sh, b_sh shift right by 1; cnt++
//       When cnt==WIDTH-1 (last bit), go to DONE. sum<=final sum_sh and
//       cout<=fa.cout are registered in that same edge.
//     DONE: out_valid=1; sum/cout stable while out_valid && !out_ready.
//       out_ready=1, in_valid=0: clear out_valid, go to IDLE.
//       out_ready=1, in_valid=1: in_ready=1 (in_ready = IDLE | DONE&out_ready).
//         Result retires and the new operands are captured in the same edge;
//         go straight to RUN.
//       out_ready=0: in_ready=0, state unchanged.
//   Latency: operands accepted at edge N give out_valid high after edge
//     N+WIDTH, i.e. WIDTH RUN cycles. Back-to-back throughput is one result
//     per WIDTH+1 cycles.
//   Arithmetic: {cout,sum} == a+b+cin exactly (WIDTH+1 bits); no overflow flag.
//   a/b/cin are sampled only on accept; later changes have no effect.
//   sum/cout hold their last value after retire until the next result.
//   cnt width is $clog2(WIDTH); the counter never wraps past WIDTH-1.
// TESTING (WIDTH=4 unless noted)
//   1 a=5,b=3,cin=0, out_ready=1 -> out_valid 4 cycles after accept,
//     sum=8, cout=0, busy high for exactly 4 cycles.
//   2 a=F,b=1,cin=0 -> sum=0, cout=1 (full carry ripple); then a=F,b=F,
//     cin=1 -> sum=F, cout=1.
//   3 Backpressure: result a=9,b=6,cin=1 (sum=0,cout=1) with out_ready=0
//     for 7 cycles -> out_valid, sum, cout held and in_ready=0 throughout;
//     retires on the first out_ready=1 cycle.
//   4 Back-to-back: in_valid held high with 3 operand sets, out_ready=1 ->
//     one accept every 5 cycles, results in order, no lost or duplicate
//     out_valid pulses.
//   5 Reset mid-RUN: assert rst_n=0 at bit 2 of a=A,b=5 -> outputs zero
//     immediately (async). After release, in_ready=1 and no stale out_valid.
//   6 Exhaustive: all 512 {a,b,cin} combinations -> {cout,sum}==a+b+cin.
//     Repeat for WIDTH=8 with 1000 random vectors.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder bit per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;

    // Full adder built from two half adders
    logic ha1_s, ha1_c, ha2_c;
    logic fa_s, fa_c;

    assign ha1_s = a_sh[0] ^ b_sh[0];
    assign ha1_c = a_sh[0] & b_sh[0];
    assign fa_s  = ha1_s ^ carry;
    assign ha2_c = ha1_s & carry;
    assign fa_c  = ha1_c | ha2_c;

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign last   = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= fa_c;
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            // Counter parks on the last bit rather than wrapping
            if (!last) cnt <= cnt + 1'b1;
            if (last) begin
                sum  <= {fa_s, sum_sh[WIDTH-1:1]};
                cout <= fa_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=4 directed and
// exhaustive vectors, plus a WIDTH=8 instance with random vectors.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] a, b, sum;
    logic       cin, cout, busy;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cout8, busy8;

    int ntests = 0;
    int nfail  = 0;

    int idx, nret, npulse;
    int acc_cyc [3];
    logic prev_ov;
    logic [3:0] ta [3] = '{4'h3, 4'hA, 4'hC};
    logic [3:0] tb [3] = '{4'h4, 4'h7, 4'hC};
    logic       tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0] es [3] = '{4'h7, 4'h2, 4'h8};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        ntests++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          input logic cv, input string tag);
        logic [4:0] r;
        int lat, nb;
        r = {1'b0, av} + {1'b0, bv} + {4'b0, cv};
        out_ready = 1'b1;
        #1;
        chk({tag, " in_ready"}, in_ready, 1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
        lat = 0; nb = 0;
        while (!out_valid && lat < 20) begin
            nb += int'(busy);
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 4);
        chk({tag, " busy_cycles"}, nb, 4);
        chk({tag, " sum"}, sum, r[3:0]);
        chk({tag, " cout"}, cout, r[4]);
        tick();
        chk({tag, " retired"}, out_valid, 0);
    endtask

    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                           input logic cv);
        logic [8:0] r;
        int lat;
        r = {1'b0, av} + {1'b0, bv} + {8'b0, cv};
        out_ready8 = 1'b1;
        a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 30) begin
            tick();
            lat++;
        end
        chk("w8 latency", lat, 8);
        chk("w8 result", {cout8, sum8}, r);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        #12;
        chk("rst out_valid", out_valid, 0);
        chk("rst sum", sum, 0);
        chk("rst cout", cout, 0);
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst w8 out_valid", out_valid8, 0);
        #2 rst_n = 1'b1;
        tick();

        // basic add and full carry ripple
        run_op(4'h5, 4'h3, 1'b0, "t1 5+3");
        run_op(4'hF, 4'h1, 1'b0, "t2 F+1");
        run_op(4'hF, 4'hF, 1'b1, "t2 F+F+1");

        // backpressure hold
        out_ready = 1'b0;
        a = 4'h9; b = 4'h6; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        idx = 0;
        while (!out_valid && idx < 20) begin
            tick();
            idx++;
        end
        chk("t3 latency", idx, 4);
        for (int i = 0; i < 7; i++) begin
            chk("t3 hold out_valid", out_valid, 1);
            chk("t3 hold sum", sum, 4'h0);
            chk("t3 hold cout", cout, 1);
            chk("t3 hold in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t3 in_ready on take", in_ready, 1);
        tick();
        chk("t3 retired", out_valid, 0);
        chk("t3 sum kept", sum, 4'h0);
        chk("t3 cout kept", cout, 1);

        // back-to-back stream
        idx = 0; nret = 0; npulse = 0; prev_ov = out_valid;
        a = ta[0]; b = tb[0]; cin = tc[0];
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            logic acc;
            acc = in_valid && in_ready;
            if (out_valid && !prev_ov) npulse++;
            prev_ov = out_valid;
            if (out_valid && out_ready && nret < 3) begin
                chk("t4 sum", sum, es[nret]);
                chk("t4 cout", cout, ec[nret]);
                nret++;
            end
            tick();
            if (acc && idx < 3) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    a = ta[idx]; b = tb[idx]; cin = tc[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("t4 accepts", idx, 3);
        chk("t4 results", nret, 3);
        chk("t4 pulses", npulse, 3);
        chk("t4 spacing 0-1", acc_cyc[1] - acc_cyc[0], 5);
        chk("t4 spacing 1-2", acc_cyc[2] - acc_cyc[1], 5);

        // async reset in the middle of RUN
        out_ready = 1'b1;
        a = 4'hA; b = 4'h5; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t5 busy before rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 rst out_valid", out_valid, 0);
        chk("t5 rst sum", sum, 0);
        chk("t5 rst cout", cout, 0);
        chk("t5 rst busy", busy, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("t5 in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            chk("t5 no stale out_valid", out_valid, 0);
            tick();
        end
        run_op(4'hA, 4'h5, 1'b0, "t5 recover");

        // exhaustive WIDTH=4
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            run_op(v[8:5], v[4:1], v[0], "t6 exh");
        end

        // random WIDTH=8
        run_op8(8'hFF, 8'hFF, 1'b1);
        run_op8(8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 1000; i++)
            run_op8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
